// File: rtl/mem_pkg.sv
// mem_pkg: widths, arbiter state type and burst-size helper shared by the
// DDR2 local-port arbiter, the memory wrapper and its clients.
package mem_pkg;

  // Local word address width
  localparam int ADDR_W    = 24;
  // Local data width (half-rate, 16-bit DDR2)
  localparam int DATA_W    = 64;
  // Burst-length field width
  localparam int SIZE_W    = 3;
  // Largest burst the controller is configured for
  localparam int MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } mem_arb_state_t;

  // Map a client size field onto a legal controller burst length.
  // Zero means a single beat; values past MAX_BURST are clamped so the
  // controller never sees a burst it was not generated for.
  function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] size);
    logic [SIZE_W-1:0] res;
    res = size;
    if (size == '0) begin
      res = SIZE_W'(1);
    end else if (int'(size) > MAX_BURST) begin
      res = SIZE_W'(MAX_BURST);
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: Avalon-style HPC local port between the arbiter (master)
// and the DDR2 controller (slave).
interface mem_arbiter_if;
  import mem_pkg::*;

  logic [ADDR_W-1:0]   local_address;
  logic [SIZE_W-1:0]   local_size;
  logic                local_burstbegin;
  logic                local_write_req;
  logic                local_read_req;
  logic [DATA_W-1:0]   local_wdata;
  logic [DATA_W/8-1:0] local_be;
  logic                local_ready;
  logic [DATA_W-1:0]   local_rdata;
  logic                local_rdata_valid;

  modport master (
    output local_address,
    output local_size,
    output local_burstbegin,
    output local_write_req,
    output local_read_req,
    output local_wdata,
    output local_be,
    input  local_ready,
    input  local_rdata,
    input  local_rdata_valid
  );

  modport slave (
    input  local_address,
    input  local_size,
    input  local_burstbegin,
    input  local_write_req,
    input  local_read_req,
    input  local_wdata,
    input  local_be,
    output local_ready,
    output local_rdata,
    output local_rdata_valid
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the DDR2 controller local port between the DAQ write
// client and the readout read client, gates traffic on controller init and
// frames each client request as one local burst. Read beats in flight are
// tracked so the controller's return path is never over-subscribed.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_OUTST = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              init_done,
  // write client
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SIZE_W-1:0] wr_size,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_ack,
  // read client
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [SIZE_W-1:0] rd_size,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              busy,
  // controller local port
  mem_arbiter_if.master     local_bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_wr_bursts,
  output logic [31:0]       stat_rd_bursts,
  output logic [31:0]       stat_stall
`endif
);

  localparam int OUTST_W = $clog2(MAX_OUTST + 1);

  mem_arb_state_t     state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [SIZE_W-1:0]  size_reg, size_next;
  logic [SIZE_W-1:0]  beat_reg, beat_next;
  logic [OUTST_W-1:0] outst_reg, outst_next;
  logic               last_wr_reg, last_wr_next;

  logic [SIZE_W-1:0]  wr_size_n;
  logic [SIZE_W-1:0]  rd_size_n;
  logic               rd_fits;
  logic               rd_elig;
  logic               grant_wr;
  logic               grant_rd;
  logic [SIZE_W-1:0]  outst_add;
  logic               outst_dec;
  int                 outst_sum;

  assign wr_size_n = norm_size(wr_size);
  assign rd_size_n = norm_size(rd_size);

  // A read may only start if its whole burst fits in the in-flight budget,
  // so the returned beats can always be absorbed by the readout path.
  assign rd_fits  = (int'(outst_reg) + int'(rd_size_n)) <= MAX_OUTST;
  assign rd_elig  = rd_req & rd_fits;

  // Round-robin on a tie: the client not served last wins.
  assign grant_wr = init_done & wr_req  & (~rd_elig | ~last_wr_reg);
  assign grant_rd = init_done & rd_elig & (~wr_req  | last_wr_reg);

  // Read return is a straight pass-through: no added latency.
  assign rd_data       = local_bus.local_rdata;
  assign rd_data_valid = local_bus.local_rdata_valid;
  assign outst_dec     = local_bus.local_rdata_valid;

  assign local_bus.local_be      = '1;
  assign local_bus.local_address = addr_reg;
  assign local_bus.local_size    = size_reg;

  assign busy = (state_reg != IDLE) || (outst_reg != '0);

  // State, latched burst parameters, beat counter and arbitration history
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      size_reg    <= '0;
      beat_reg    <= '0;
      outst_reg   <= '0;
      last_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      size_reg    <= size_next;
      beat_reg    <= beat_next;
      outst_reg   <= outst_next;
      last_wr_reg <= last_wr_next;
    end
  end

  // Next state, local-port strobes and client handshakes
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    size_next    = size_reg;
    beat_next    = beat_reg;
    last_wr_next = last_wr_reg;
    outst_add    = '0;

    local_bus.local_write_req  = 1'b0;
    local_bus.local_read_req   = 1'b0;
    local_bus.local_burstbegin = 1'b0;
    local_bus.local_wdata      = '0;
    wr_data_ack                = 1'b0;
    rd_ack                     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_wr) begin
          state_next = WR;
          addr_next  = wr_addr;
          size_next  = wr_size_n;
          beat_next  = '0;
        end else if (grant_rd) begin
          state_next = RD;
          addr_next  = rd_addr;
          size_next  = rd_size_n;
          beat_next  = '0;
        end
      end

      WR: begin
        local_bus.local_write_req  = 1'b1;
        local_bus.local_wdata      = wr_data;
        // Held on the first beat until the controller takes it
        local_bus.local_burstbegin = (beat_reg == '0);
        wr_data_ack                = local_bus.local_ready;
        if (local_bus.local_ready) begin
          if (beat_reg == size_reg - SIZE_W'(1)) begin
            state_next   = IDLE;
            beat_next    = '0;
            last_wr_next = 1'b1;
          end else begin
            beat_next = beat_reg + SIZE_W'(1);
          end
        end
      end

      RD: begin
        local_bus.local_read_req   = 1'b1;
        local_bus.local_burstbegin = 1'b1;
        if (local_bus.local_ready) begin
          rd_ack       = 1'b1;
          outst_add    = size_reg;
          last_wr_next = 1'b0;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outstanding read beats: net of command accept and returned beat, clamped
  // at both ends so a spurious return beat can never wrap the counter
  always_comb begin
    outst_sum = int'(outst_reg) + int'(outst_add) - (outst_dec ? 1 : 0);
    if (outst_sum < 0) begin
      outst_sum = 0;
    end
    if (outst_sum > MAX_OUTST) begin
      outst_sum = MAX_OUTST;
    end
    outst_next = OUTST_W'(outst_sum);
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_wr_reg;
  logic [31:0] stat_rd_reg;
  logic [31:0] stat_stall_reg;
  logic        wr_done;
  logic        stall_cycle;

  assign wr_done     = wr_data_ack && (beat_reg == size_reg - SIZE_W'(1));
  assign stall_cycle = (local_bus.local_write_req | local_bus.local_read_req)
                       & ~local_bus.local_ready;

  // Saturating burst and stall counters
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      stat_wr_reg    <= '0;
      stat_rd_reg    <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (wr_done && (stat_wr_reg != '1)) begin
        stat_wr_reg <= stat_wr_reg + 32'd1;
      end
      if (rd_ack && (stat_rd_reg != '1)) begin
        stat_rd_reg <= stat_rd_reg + 32'd1;
      end
      if (stall_cycle && (stat_stall_reg != '1)) begin
        stat_stall_reg <= stat_stall_reg + 32'd1;
      end
    end
  end

  assign stat_wr_bursts = stat_wr_reg;
  assign stat_rd_bursts = stat_rd_reg;
  assign stat_stall     = stat_stall_reg;
`endif

endmodule
